// File: rtl/memory_initiator_pkg.sv
// -----------------------------------------------------------------------------
// memory_initiator_pkg
// Shared types and width defaults for the memory request initiator.
//   mi_state_e : initiator FSM states
//   mi_cmd_t   : burst command bundle {write, addr, len}
//   MI_*_WIDTH : default widths (must match the single-port memory)
// -----------------------------------------------------------------------------
package memory_initiator_pkg;

    localparam int unsigned MI_ADDR_WIDTH = 2;
    localparam int unsigned MI_DATA_WIDTH = 8;
    localparam int unsigned MI_LEN_WIDTH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_ISSUE,
        ST_RD_CAPTURE,
        ST_RD_RESP
    } mi_state_e;

    typedef struct packed {
        logic                     write;
        logic [MI_ADDR_WIDTH-1:0] addr;
        logic [MI_LEN_WIDTH-1:0]  len;
    } mi_cmd_t;

endpackage

// File: rtl/memory_initiator.sv
// -----------------------------------------------------------------------------
// memory_initiator
// Request-side master for a single-port memory. Accepts burst read/write
// commands, drives the memory enables/address/write data one beat at a time
// and returns read beats over a valid/ready response channel.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o        command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_len_i                      burst direction, start address, beats-1
//   wd_valid_i/wd_ready_o,
//   wd_data_i                      write-data channel
//   rd_valid_o/rd_ready_i,
//   rd_data_o, rd_last_o           read-response channel
//   mem_addr_o, mem_wr_en_o,
//   mem_rd_en_o, mem_wdata_o       registered memory request
//   mem_rdata_i                    memory read data (valid the cycle after rd_en)
//   busy_o                         not idle
//   done_o                         one-cycle pulse after a burst's final beat
// -----------------------------------------------------------------------------
module memory_initiator
    import memory_initiator_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MI_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MI_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = MI_LEN_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wd_valid_i,
    output logic                  wd_ready_o,
    input  logic [DATA_WIDTH-1:0] wd_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_last_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wr_en_o,
    output logic                  mem_rd_en_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  CNT_DEC  = LEN_WIDTH'(1);

    mi_state_e             state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
    logic                  rd_valid_q,  rd_valid_d;
    logic                  rd_last_q,   rd_last_d;
    logic                  done_q,      done_d;

    // The read enable is launched on the same edge that enters RD_ISSUE, so
    // RD_ISSUE is the cycle the enable is visible at the memory and
    // RD_CAPTURE is the cycle the memory's rdata is valid.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_en_d = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i;
                    cnt_d  = cmd_len_i;
                    if (cmd_write_i) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d     = ST_RD_ISSUE;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = cmd_addr_i;
                    end
                end
            end
            ST_WR_DATA: begin
                if (wd_valid_i) begin
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wd_data_i;
                    addr_d      = addr_q + ADDR_INC;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_DEC;
                    end
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                rd_data_d  = mem_rdata_i;
                rd_valid_d = 1'b1;
                rd_last_d  = (cnt_q == '0);
                state_d    = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (rd_ready_i) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d      = addr_q + ADDR_INC;
                        cnt_d       = cnt_q - CNT_DEC;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = addr_q + ADDR_INC;
                        state_d     = ST_RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign wd_ready_o  = (state_q == ST_WR_DATA);
    assign busy_o      = (state_q != ST_IDLE);
    assign mem_addr_o  = mem_addr_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_last_o   = rd_last_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_memory_initiator.sv
// -----------------------------------------------------------------------------
// tb_memory_initiator
// Bench for memory_initiator: a behavioural single-port memory (reset value
// 8'hFF per word), a transaction-level reference model of the initiator, a
// per-cycle compare process, and directed plus randomized stimulus.
// -----------------------------------------------------------------------------
module tb_memory_initiator;
    import memory_initiator_pkg::*;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int LW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wd_valid = 1'b0;
    logic          wd_ready;
    logic [DW-1:0] wd_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;

    memory_initiator #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write),
        .cmd_addr_i (cmd_addr),
        .cmd_len_i  (cmd_len),
        .wd_valid_i (wd_valid),
        .wd_ready_o (wd_ready),
        .wd_data_i  (wd_data),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .rd_last_o  (rd_last),
        .mem_addr_o (mem_addr),
        .mem_wr_en_o(mem_wr_en),
        .mem_rd_en_o(mem_rd_en),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    // ---------------- single-port memory ----------------
    logic [DW-1:0] mem [DEPTH] = '{default: '1};
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // ---------------- observation logs ----------------
    int            cyc = 0;
    int            done_cnt = 0;
    logic [AW-1:0] wl_addr [$];
    logic [DW-1:0] wl_data [$];
    int            wl_cyc  [$];
    always @(posedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (mem_wr_en) begin
            wl_addr.push_back(mem_addr);
            wl_data.push_back(mem_wdata);
            wl_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        wl_addr.delete();
        wl_data.delete();
        wl_cyc.delete();
    endtask

    // ---------------- reference model ----------------
    // Burst-level view: beats remaining, direction, current address, and for
    // reads a countdown until the response is due.
    logic [DW-1:0] ref_mem [DEPTH] = '{default: '1};
    int            m_left = 0;
    bit            m_wr = 1'b0;
    logic [AW-1:0] m_cur = '0;
    int            m_wait = 0;
    bit            e_wr_en = 1'b0, e_rd_en = 1'b0, e_done = 1'b0;
    bit            e_rd_valid = 1'b0, e_rd_last = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_rd_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_wait = 0;
            e_wr_en = 1'b0; e_rd_en = 1'b0; e_done = 1'b0;
            e_rd_valid = 1'b0; e_rd_last = 1'b0;
        end else begin
            e_wr_en = 1'b0; e_rd_en = 1'b0; e_done = 1'b0;
            if (m_left == 0) begin
                if (cmd_valid) begin
                    m_left = int'(cmd_len) + 1;
                    m_wr   = cmd_write;
                    m_cur  = cmd_addr;
                    if (!m_wr) begin
                        e_rd_en = 1'b1; e_addr = m_cur; m_wait = 2;
                    end
                end
            end else if (m_wr) begin
                if (wd_valid) begin
                    e_wr_en = 1'b1; e_addr = m_cur; e_wdata = wd_data;
                    ref_mem[m_cur] = wd_data;
                    m_cur = m_cur + AW'(1);
                    m_left--;
                    if (m_left == 0) e_done = 1'b1;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    e_rd_valid = 1'b1;
                    e_rd_data  = ref_mem[m_cur];
                    e_rd_last  = (m_left == 1);
                end
            end else if (rd_ready) begin
                e_rd_valid = 1'b0; e_rd_last = 1'b0;
                m_left--;
                if (m_left == 0) begin
                    e_done = 1'b1;
                end else begin
                    m_cur = m_cur + AW'(1);
                    e_rd_en = 1'b1; e_addr = m_cur; m_wait = 2;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cmd_ready", 32'(cmd_ready), 32'(m_left == 0));
        check("wd_ready",  32'(wd_ready),  32'(m_left != 0 && m_wr));
        check("busy",      32'(busy),      32'(m_left != 0));
        check("done",      32'(done),      32'(e_done));
        check("mem_wr_en", 32'(mem_wr_en), 32'(e_wr_en));
        check("mem_rd_en", 32'(mem_rd_en), 32'(e_rd_en));
        check("rd_valid",  32'(rd_valid),  32'(e_rd_valid));
        check("en_exclusive", 32'(mem_wr_en && mem_rd_en), 32'(0));
        if (e_wr_en || e_rd_en) check("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_wr_en) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        if (e_rd_valid) begin
            check("rd_data", 32'(rd_data), 32'(e_rd_data));
            check("rd_last", 32'(rd_last), 32'(e_rd_last));
        end
    end

    // ---------------- drivers (called at a negedge) ----------------
    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n = 0;
        cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        while (!cmd_ready) begin
            @(negedge clk); n++;
            if (n > 50) begin timeout("cmd_handshake"); break; end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // gap idle cycles precede the beat; stray cmd_valid is thrown in there
    task automatic wbeat(input logic [DW-1:0] data, input int gap);
        int n = 0;
        wd_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            cmd_valid = 1'($urandom);
            cmd_write = 1'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_len   = LW'($urandom);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wd_valid = 1'b1; wd_data = data;
        while (!wd_ready) begin
            @(negedge clk); n++;
            if (n > 50) begin timeout("wd_handshake"); break; end
        end
        @(negedge clk);
        wd_valid = 1'b0;
    endtask

    task automatic rresp(input int delay, output logic [DW-1:0] d, output logic l);
        int n = 0;
        d = '0; l = 1'b1;
        while (!rd_valid) begin
            @(negedge clk); n++;
            if (n > 50) begin timeout("rd_valid_wait"); return; end
        end
        d = rd_data; l = rd_last;
        for (int i = 0; i < delay; i++) begin
            wd_valid = 1'($urandom);
            @(negedge clk);
        end
        wd_valid = 1'b0;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DW-1:0] d;
        logic          l;
        logic [DW-1:0] exp3 [3];
        int            d0, lat, beats;
        mi_cmd_t       c;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_rd_valid",  32'(rd_valid),  32'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);

        // single read of unwritten address 2
        d0 = done_cnt;
        do_cmd(1'b0, 2'd2, 4'd0);
        lat = 0;
        while (!rd_valid && lat < 10) begin @(negedge clk); lat++; end
        check("rd_latency", 32'(lat), 32'(2));
        check("rd0_data", 32'(rd_data), 32'h0000_00FF);
        check("rd0_last", 32'(rd_last), 32'(1));
        rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rd0_done_once", 32'(done_cnt - d0), 32'(1));

        // back-to-back write burst and readback
        exp3[0] = 8'hA1; exp3[1] = 8'hA2; exp3[2] = 8'hA3;
        clear_log();
        do_cmd(1'b1, 2'd1, 4'd2);
        for (int i = 0; i < 3; i++) wbeat(exp3[i], 0);
        repeat (2) @(negedge clk);
        check("wr3_count", 32'(wl_addr.size()), 32'(3));
        if (wl_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("wr3_addr", 32'(wl_addr[i]), 32'(i + 1));
                check("wr3_data", 32'(wl_data[i]), 32'(exp3[i]));
            end
            check("wr3_consecutive", 32'(wl_cyc[2] - wl_cyc[0]), 32'(2));
        end
        do_cmd(1'b0, 2'd1, 4'd2);
        for (int i = 0; i < 3; i++) begin
            rresp(0, d, l);
            check("rb3_data", 32'(d), 32'(exp3[i]));
            check("rb3_last", 32'(l), 32'(i == 2));
        end

        // wrap-around write 3 -> 0
        clear_log();
        do_cmd(1'b1, 2'd3, 4'd1);
        wbeat(8'h11, 0);
        wbeat(8'h22, 0);
        repeat (2) @(negedge clk);
        check("wrap_count", 32'(wl_addr.size()), 32'(2));
        if (wl_addr.size() == 2) begin
            check("wrap_addr0", 32'(wl_addr[0]), 32'(3));
            check("wrap_addr1", 32'(wl_addr[1]), 32'(0));
        end
        do_cmd(1'b0, 2'd3, 4'd0);
        rresp(0, d, l);
        check("wrap_rd3", 32'(d), 32'h11);
        do_cmd(1'b0, 2'd0, 4'd0);
        rresp(0, d, l);
        check("wrap_rd0", 32'(d), 32'h22);

        // backpressure: first beat held 5 cycles
        do_cmd(1'b0, 2'd3, 4'd1);
        lat = 0;
        while (!rd_valid && lat < 10) begin @(negedge clk); lat++; end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rd_valid), 32'(1));
            check("bp_data",  32'(rd_data),  32'h11);
            check("bp_no_rd", 32'(mem_rd_en), 32'(0));
            @(negedge clk);
        end
        rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
        rresp(0, d, l);
        check("bp_beat2", 32'(d), 32'h22);
        check("bp_last2", 32'(l), 32'(1));

        // write with an idle cycle between beats
        clear_log();
        do_cmd(1'b1, 2'd2, 4'd1);
        wbeat(8'h5C, 0);
        wbeat(8'hC5, 1);
        repeat (2) @(negedge clk);
        check("gap_count", 32'(wl_addr.size()), 32'(2));
        if (wl_addr.size() == 2) begin
            check("gap_data0", 32'(wl_data[0]), 32'h5C);
            check("gap_data1", 32'(wl_data[1]), 32'hC5);
        end

        // maximum burst length, both directions
        clear_log();
        do_cmd(1'b1, 2'd0, 4'hF);
        for (int i = 0; i < 16; i++) wbeat(DW'($urandom), 0);
        repeat (2) @(negedge clk);
        check("max_wr_count", 32'(wl_addr.size()), 32'(16));
        do_cmd(1'b0, 2'd1, 4'hF);
        beats = 0;
        do begin
            rresp(0, d, l);
            beats++;
        end while (!l && beats < 20);
        check("max_rd_beats", 32'(beats), 32'(16));

        // randomized bursts
        for (int it = 0; it < 40; it++) begin
            c.write = 1'($urandom);
            c.addr  = AW'($urandom);
            c.len   = ($urandom_range(0, 3) == 0) ? LW'($urandom) : LW'($urandom_range(0, 2));
            do_cmd(c.write, c.addr, c.len);
            for (int b = 0; b <= int'(c.len); b++) begin
                if (c.write) wbeat(DW'($urandom), $urandom_range(0, 2));
                else rresp($urandom_range(0, 3), d, l);
            end
        end

        // reset after one of three write beats
        repeat (2) @(negedge clk);
        clear_log();
        d0 = done_cnt;
        do_cmd(1'b1, 2'd0, 4'd2);
        wbeat(8'h77, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("arst_busy",      32'(busy),      32'(0));
        check("arst_wd_ready",  32'(wd_ready),  32'(0));
        check("arst_wr_en",     32'(mem_wr_en), 32'(0));
        check("arst_rd_en",     32'(mem_rd_en), 32'(0));
        check("arst_mem_addr",  32'(mem_addr),  32'(0));
        check("arst_mem_wdata", 32'(mem_wdata), 32'(0));
        check("arst_rd_valid",  32'(rd_valid),  32'(0));
        check("arst_rd_data",   32'(rd_data),   32'(0));
        check("arst_done",      32'(done),      32'(0));
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_done",  32'(done_cnt - d0), 32'(0));
        check("arst_wr_count", 32'(wl_addr.size()), 32'(1));
        if (wl_addr.size() == 1) begin
            check("arst_wr_addr", 32'(wl_addr[0]), 32'(0));
            check("arst_wr_data", 32'(wl_data[0]), 32'h77);
        end
        do_cmd(1'b0, 2'd0, 4'd0);
        rresp(0, d, l);
        check("arst_readback", 32'(d), 32'h77);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_initiator.md
# memory_initiator

Request-side master for the single-port memory model: accepts burst read/write commands over valid/ready channels and drives the memory's `addr`/`wr_en`/`rd_en`/`wdata`, capturing `rdata` one cycle after each issued read. It sits between bench or agent stimulus and the memory, and is the counterpart the memory block responds to. Bursts use incrementing, wrapping addresses; one beat is in flight at a time.

## Interface
- `ADDR_WIDTH`, 2, memory address width; must match the memory.
- `DATA_WIDTH`, 8, memory data width; must match the memory.
- `LEN_WIDTH`, 4, burst length field width; beats = `cmd_len`+1.

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  ADDR_WIDTH  start address.
- `cmd_len`  in  LEN_WIDTH  beats minus one.
- `wd_valid` / `wd_ready`  in/out  1  write-data handshake.
- `wd_data`  in  DATA_WIDTH  write beat.
- `rd_valid` / `rd_ready`  out/in  1  read-response handshake.
- `rd_data`  out  DATA_WIDTH  read beat.
- `rd_last`  out  1  final beat of read burst, qualified by `rd_valid`.
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`.
- `mem_wr_en`, `mem_rd_en`  out  1  to memory enables.
- `mem_wdata`  out  DATA_WIDTH  to memory `wdata`.
- `mem_rdata`  in  DATA_WIDTH  from memory `rdata`.
- `busy`  out  1  high in any state but IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.

## Operation
- States: IDLE, WR_DATA, RD_ISSUE, RD_CAPTURE, RD_RESP.
- IDLE: `cmd_ready`=1. On handshake latch addr, beat counter = `cmd_len`, go WR_DATA or RD_ISSUE.
- WR_DATA: `wd_ready`=1. Each `wd` handshake registers `mem_wr_en`=1, `mem_addr`=current addr, `mem_wdata`=`wd_data` for exactly one cycle; addr += 1, counter -= 1. On last beat: `done` pulse, go IDLE.
- RD_ISSUE: `mem_rd_en`=1 with current addr for one cycle → RD_CAPTURE.
- RD_CAPTURE: register `mem_rdata` into `rd_data`, set `rd_valid`, `rd_last` = (counter==0) → RD_RESP.
- RD_RESP: hold `rd_data`/`rd_valid`/`rd_last` stable until `rd_ready`. On handshake: last → `done` pulse, IDLE; else addr += 1, counter -= 1, RD_ISSUE.
- Address increment wraps modulo 2**ADDR_WIDTH (3 → 0 at default width); no error.
- `cmd_len` = all-ones gives 2**LEN_WIDTH beats; counter never underflows.
- `wd_valid` outside WR_DATA and `cmd_valid` outside IDLE are ignored, not consumed.
- `mem_wr_en` and `mem_rd_en` are never high together.

## Timing
- Reset (`reset`=0): state IDLE; all outputs 0 except `cmd_ready`=1. Takes effect immediately, no clock needed. Mid-burst reset aborts the burst: no `done`, no further responses, memory enables drop at once.
- All memory-side and response outputs are registered.
- Write: `wd` handshake at edge E → `mem_wr_en` high E to E+1; memory writes at E+1. Back-to-back beats run one per cycle.
- Read: `cmd` handshake at E0 → `mem_rd_en` high E0 to E1 → memory updates `rdata` at E1 → `rd_valid` high from E2. First-beat latency is 2 cycles. With `rd_ready` held high, steady throughput is one beat per 3 cycles.
- `done` is high for the cycle after the final handshake edge. `cmd_ready` returns in that same cycle.

## Structure
- Package `memory_initiator_pkg` holds:
  - the state enum `mi_state_e`;
  - `localparam` defaults for the widths;
  - the command struct `mi_cmd_t` {write, addr, len}.
- No sub-module. The address/beat counter stays inline.

## Test plan
- Reset, then single read of addr 2 with no prior write → `rd_data`=8'hFF, `rd_last`=1, `rd_valid` at E0+2, `done` once.
- Write burst addr 1, len 2, data 8'hA1, 8'hA2, 8'hA3 back-to-back → `mem_wr_en` 3 consecutive cycles at addrs 1, 2, 3. Read back → same data in order, `rd_last` only on 8'hA3.
- Wrap-around: write burst addr 3, len 1, data 8'h11, 8'h22 → writes land at addr 3 then 0. Reads of addr 3 and 0 return 8'h11 and 8'h22.
- Backpressure: read len 1 with `rd_ready` low 5 cycles → `rd_data`/`rd_valid` stable throughout, no second `mem_rd_en` until the handshake.
- `wd_valid` gaps: write len 1 with one idle cycle between beats → exactly 2 `mem_wr_en` pulses, each carrying the correct data.
- Reset asserted during WR_DATA after 1 of 3 beats → outputs 0 immediately, `cmd_ready`=1, no `done`. Only beat 1 is written.
